// File: rtl/insmem_loadable.sv
// insmem_loadable -- single-clock loadable instruction memory.
//
// A program is streamed in through a valid/ready loader port. It is written
// at auto-incrementing addresses starting from 0. After the load completes,
// the core fetch stage reads registered instructions by PC.
//
// Optional feature: when the macro INSMEM_PARITY_EN is defined, each word
// stores an even-parity bit. Every fetch rechecks that bit, and the result
// appears on the extra output parity_err.
//
// Ports:
//   clka            sole clock, rising edge
//   rst             synchronous active-high reset
//   ld_start        pulse: begin a (re)load at address 0
//   ld_valid        ld_data valid this cycle
//   ld_ready        block accepts a load word this cycle (high in S_LOAD)
//   ld_data         program word to write
//   ld_last         marks the final program word
//   ld_done         a load has completed; fetch enabled
//   ld_overflow     load ended by filling the array without ld_last
//   ld_count        words written by current/last load (0..DEPTH)
//   fetch_en        fetch request
//   pc              fetch address
//   instruction_out registered fetched instruction (NOP_WORD when refused)
//   instr_valid     instruction_out holds a fetch from the previous cycle
//   parity_err      (INSMEM_PARITY_EN only) stored parity mismatch on fetch
module insmem_loadable #(
    parameter int                     INSTR_WIDTH = 16,
    parameter int                     PC_BITS     = 6,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = 16'h0000
) (
    input  logic                   clka,
    input  logic                   rst,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [INSTR_WIDTH-1:0] ld_data,
    input  logic                   ld_last,
    output logic                   ld_done,
    output logic                   ld_overflow,
    output logic [PC_BITS:0]       ld_count,
    input  logic                   fetch_en,
    input  logic [PC_BITS-1:0]     pc,
    output logic [INSTR_WIDTH-1:0] instruction_out,
`ifdef INSMEM_PARITY_EN
    output logic                   parity_err,
`endif
    output logic                   instr_valid
);

    localparam int DEPTH = 32'd1 << PC_BITS;
    localparam logic [PC_BITS-1:0] LAST_ADDR  = {PC_BITS{1'b1}};
    localparam logic [PC_BITS-1:0] ADDR_ZERO  = {PC_BITS{1'b0}};
    localparam logic [PC_BITS-1:0] ADDR_ONE   = {{(PC_BITS-1){1'b0}}, 1'b1};
    localparam logic [PC_BITS:0]   CNT_ZERO   = {(PC_BITS+1){1'b0}};
    localparam logic [PC_BITS:0]   CNT_ONE    = {{PC_BITS{1'b0}}, 1'b1};
    localparam logic [PC_BITS:0]   CNT_FULL   = {1'b1, {PC_BITS{1'b0}}};
    localparam logic [INSTR_WIDTH-1:0] WORD_ZERO = {INSTR_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10
    } state_t;

`ifdef INSMEM_PARITY_EN
    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_parity(input logic [INSTR_WIDTH-1:0] word);
        even_parity = ^word;
    endfunction

    // Recheck the stored bit; a nonzero XOR over word+bit means corruption.
    function automatic logic parity_bad(input logic [INSTR_WIDTH-1:0] word,
                                        input logic                   par);
        parity_bad = (^word) ^ par;
    endfunction
`endif

    state_t                   state_r, next_state_s;
    logic [PC_BITS-1:0]       waddr_r;
    logic [PC_BITS:0]         ld_count_r;
    logic                     ld_ready_r;
    logic                     ld_done_r;
    logic                     ld_overflow_r;
    logic [INSTR_WIDTH-1:0]   instruction_out_r;
    logic                     instr_valid_r;
    logic                     xfer_s;
    logic                     at_end_s;
    logic                     load_end_s;
    logic                     wr_en_s;

    logic [INSTR_WIDTH-1:0]   mem_r [DEPTH];
`ifdef INSMEM_PARITY_EN
    logic                     mem_par_r [DEPTH];
    logic                     parity_err_r;
`endif

    // Handshake decode and next-state selection.
    always_comb begin
        next_state_s = state_r;
        xfer_s       = (state_r == S_LOAD) && ld_valid;
        at_end_s     = (waddr_r == LAST_ADDR);
        load_end_s   = xfer_s && (ld_last || at_end_s);
        wr_en_s      = xfer_s && !rst;
        case (state_r)
            S_IDLE: begin
                if (ld_start) begin
                    next_state_s = S_LOAD;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                // ld_start is ignored mid-load; only a final transfer leaves.
                if (load_end_s) begin
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_LOAD;
                end
            end
            S_RUN: begin
                if (ld_start) begin
                    next_state_s = S_LOAD;
                end else begin
                    next_state_s = S_RUN;
                end
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Program-store write port; contents deliberately survive reset.
    always_ff @(posedge clka) begin
        if (wr_en_s) begin
            mem_r[waddr_r] <= ld_data;
`ifdef INSMEM_PARITY_EN
            mem_par_r[waddr_r] <= even_parity(ld_data);
`endif
        end
    end

    // FSM state, loader bookkeeping and registered fetch path.
    always_ff @(posedge clka) begin
        if (rst) begin
            state_r           <= S_IDLE;
            ld_ready_r        <= 1'b0;
            ld_done_r         <= 1'b0;
            ld_overflow_r     <= 1'b0;
            ld_count_r        <= CNT_ZERO;
            waddr_r           <= ADDR_ZERO;
            instruction_out_r <= WORD_ZERO;
            instr_valid_r     <= 1'b0;
`ifdef INSMEM_PARITY_EN
            parity_err_r      <= 1'b0;
`endif
        end else begin
            state_r    <= next_state_s;
            // Registered copy of "next state is S_LOAD" tracks the state exactly.
            ld_ready_r <= (next_state_s == S_LOAD);
`ifdef INSMEM_PARITY_EN
            parity_err_r <= 1'b0;
`endif
            case (state_r)
                S_IDLE, S_LOAD: begin
                    instr_valid_r <= 1'b0;
                    if (fetch_en) begin
                        instruction_out_r <= NOP_WORD;
                    end
                    if (state_r == S_IDLE && ld_start) begin
                        waddr_r       <= ADDR_ZERO;
                        ld_count_r    <= CNT_ZERO;
                        ld_overflow_r <= 1'b0;
                    end
                    if (xfer_s) begin
                        // Hold the address at the top word; a load never wraps.
                        if (!at_end_s) begin
                            waddr_r <= waddr_r + ADDR_ONE;
                        end
                        if (ld_count_r != CNT_FULL) begin
                            ld_count_r <= ld_count_r + CNT_ONE;
                        end
                        if (at_end_s && !ld_last) begin
                            ld_overflow_r <= 1'b1;
                        end
                        if (load_end_s) begin
                            ld_done_r <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (ld_start) begin
                        // Reload wins over a same-cycle fetch, which is refused.
                        ld_done_r     <= 1'b0;
                        instr_valid_r <= 1'b0;
                        waddr_r       <= ADDR_ZERO;
                        ld_count_r    <= CNT_ZERO;
                        ld_overflow_r <= 1'b0;
                        if (fetch_en) begin
                            instruction_out_r <= NOP_WORD;
                        end
                    end else if (fetch_en) begin
                        instruction_out_r <= mem_r[pc];
                        instr_valid_r     <= 1'b1;
`ifdef INSMEM_PARITY_EN
                        parity_err_r      <= parity_bad(mem_r[pc], mem_par_r[pc]);
`endif
                    end else begin
                        instr_valid_r <= 1'b0;
                    end
                end
                default: begin
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready        = ld_ready_r;
    assign ld_done         = ld_done_r;
    assign ld_overflow     = ld_overflow_r;
    assign ld_count        = ld_count_r;
    assign instruction_out = instruction_out_r;
    assign instr_valid     = instr_valid_r;
`ifdef INSMEM_PARITY_EN
    assign parity_err      = parity_err_r;
`endif

endmodule

// File: tb/tb_insmem_loadable.sv
// Self-checking bench for insmem_loadable (default parameters).
// The reference model is an array of the expected program image plus
// expected loader status. It is updated from the loader rules at each
// accepted word.
module tb_insmem_loadable;

    logic        clka = 1'b0;
    logic        rst;
    logic        ld_start;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        ld_done;
    logic        ld_overflow;
    logic [6:0]  ld_count;
    logic        fetch_en;
    logic [5:0]  pc;
    logic [15:0] instruction_out;
    logic        instr_valid;
`ifdef INSMEM_PARITY_EN
    logic        parity_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem [64];
    int          exp_count;
    logic [15:0] last_out;

    always #5 clka = ~clka;

    insmem_loadable dut (
        .clka            (clka),
        .rst             (rst),
        .ld_start        (ld_start),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_data         (ld_data),
        .ld_last         (ld_last),
        .ld_done         (ld_done),
        .ld_overflow     (ld_overflow),
        .ld_count        (ld_count),
        .fetch_en        (fetch_en),
        .pc              (pc),
        .instruction_out (instruction_out),
`ifdef INSMEM_PARITY_EN
        .parity_err      (parity_err),
`endif
        .instr_valid     (instr_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ld_ready), 32'd0);
        check({tag, "_done"},  32'(ld_done), 32'd0);
        check({tag, "_ovf"},   32'(ld_overflow), 32'd0);
        check({tag, "_count"}, 32'(ld_count), 32'd0);
        check({tag, "_out"},   32'(instruction_out), 32'h0000);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    endtask

    task automatic start_load();
        ld_start = 1'b1; ld_valid = 1'b0; fetch_en = 1'b0;
        tick();
        ld_start  = 1'b0;
        exp_count = 0;
        check("start_ready", 32'(ld_ready), 32'd1);
        check("start_done",  32'(ld_done), 32'd0);
        check("start_count", 32'(ld_count), 32'd0);
        check("start_valid", 32'(instr_valid), 32'd0);
    endtask

    task automatic send_word(input logic [15:0] d, input logic last, input bit final_word);
        check("send_ready", 32'(ld_ready), 32'd1);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        ref_mem[exp_count] = d;
        exp_count++;
        check("load_count", 32'(ld_count), 32'(exp_count));
        check("load_done",  32'(ld_done), final_word ? 32'd1 : 32'd0);
    endtask

    // Idle cycle inside a load; a stray ld_start here must be ignored.
    task automatic gap();
        ld_valid = 1'b0;
        ld_data  = 16'($urandom);
        ld_last  = 1'($urandom);
        ld_start = 1'($urandom);
        tick();
        ld_start = 1'b0; ld_last = 1'b0;
        check("gap_count", 32'(ld_count), 32'(exp_count));
        check("gap_ready", 32'(ld_ready), 32'd1);
    endtask

    task automatic check_complete(input logic ovf);
        check("end_done",  32'(ld_done), 32'd1);
        check("end_ovf",   32'(ld_overflow), 32'(ovf));
        check("end_count", 32'(ld_count), 32'(exp_count));
        check("end_ready", 32'(ld_ready), 32'd0);
    endtask

    // Load n random words; with use_last=0 n must be 64 (overflow path).
    task automatic do_load(input int n, input bit use_last, input bit gaps);
        start_load();
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) gap();
            send_word(16'($urandom), (use_last && i == n - 1) ? 1'b1 : 1'b0, i == n - 1);
        end
        check_complete(use_last ? 1'b0 : 1'b1);
    endtask

    task automatic fetch(input logic [5:0] p);
        fetch_en = 1'b1; pc = p;
        tick();
        check("fetch_valid", 32'(instr_valid), 32'd1);
        check("fetch_data",  32'(instruction_out), 32'(ref_mem[p]));
`ifdef INSMEM_PARITY_EN
        check("fetch_perr",  32'(parity_err), 32'd0);
`endif
        last_out = ref_mem[p];
    endtask

    task automatic fetch_idle();
        fetch_en = 1'b0;
        tick();
        check("idle_valid", 32'(instr_valid), 32'd0);
        check("idle_hold",  32'(instruction_out), 32'(last_out));
    endtask

    task automatic fetch_refused(input string tag);
        fetch_en = 1'b1; pc = 6'($urandom);
        tick();
        fetch_en = 1'b0;
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_nop"},   32'(instruction_out), 32'h0000);
    endtask

    task automatic random_fetches(input int n, input int span);
        for (int i = 0; i < n; i++) fetch(6'($urandom_range(span - 1, 0)));
        fetch_idle();
    endtask

    initial begin
        rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 16'h0000;
        ld_last = 1'b0; fetch_en = 1'b0; pc = 6'd0; last_out = 16'h0000;
        exp_count = 0;
        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Fetch before any load is refused.
        fetch_en = 1'b1; pc = 6'd0;
        tick();
        fetch_en = 1'b0;
        check("preload_valid", 32'(instr_valid), 32'd0);
        check("preload_out",   32'(instruction_out), 32'h0000);
        check("preload_done",  32'(ld_done), 32'd0);
        check("preload_ready", 32'(ld_ready), 32'd0);

        // Three-word directed program, then back-to-back fetches.
        start_load();
        send_word(16'h0001, 1'b0, 1'b0);
        send_word(16'h0002, 1'b0, 1'b0);
        send_word(16'h0003, 1'b1, 1'b1);
        check_complete(1'b0);
        fetch(6'd0); fetch(6'd1); fetch(6'd2);
        fetch_idle();

        // ld_valid toggling with stray ld_start in the gaps.
        do_load(4, 1'b1, 1'b1);
        fetch(6'd0); fetch(6'd1); fetch(6'd2); fetch(6'd3);
        fetch_idle();

        // Full array without ld_last: overflow termination.
        do_load(64, 1'b0, 1'b0);
        fetch(6'd63);
        random_fetches(8, 64);

        // Full array with ld_last on the top word: normal completion.
        do_load(64, 1'b1, 1'b0);
        fetch(6'd63);
        random_fetches(6, 64);

        // ld_start and fetch_en together in S_RUN: reload wins.
        ld_start = 1'b1; fetch_en = 1'b1; pc = 6'd5;
        tick();
        ld_start = 1'b0; fetch_en = 1'b0;
        exp_count = 0;
        check("prio_valid", 32'(instr_valid), 32'd0);
        check("prio_ready", 32'(ld_ready), 32'd1);
        check("prio_out",   32'(instruction_out), 32'h0000);
        send_word(16'hBEEF, 1'b1, 1'b1);
        check_complete(1'b0);
        fetch(6'd0);
        random_fetches(4, 64);

        // Reset after 2 of 5 words.
        start_load();
        send_word(16'($urandom), 1'b0, 1'b0);
        send_word(16'($urandom), 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        fetch_refused("midrst_fetch");
        last_out = 16'h0000;

        // Fresh loads with random lengths after the reset.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(20, 1);
            do_load(n, 1'b1, 1'($urandom));
            random_fetches(6, n);
        end

`ifdef INSMEM_PARITY_EN
        // Corrupt one stored parity bit and fetch that word.
        do_load(3, 1'b1, 1'b0);
        fetch(6'd1);
        dut.mem_par_r[1] = ~dut.mem_par_r[1];
        fetch_en = 1'b1; pc = 6'd1;
        tick();
        check("perr_flag",  32'(parity_err), 32'd1);
        check("perr_valid", 32'(instr_valid), 32'd1);
        fetch_en = 1'b0;
        tick();
        check("perr_clear", 32'(parity_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
